alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width in bits (legal 8..64).
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 inValid  in  1  SHALL indicate an operation is presented.
REQ-005 inReady  out  1  SHALL indicate the unit accepts the operation this cycle.
REQ-006 aluOp  in  2  SHALL be the main-decoder ALU class.
REQ-007 funct  in  6  SHALL be the R-type function field.
REQ-008 srcA, srcB  in  WIDTH  SHALL be the operands.
REQ-009 outValid  out  1  SHALL indicate the result outputs hold a completed operation.
REQ-010 outReady  in  1  SHALL indicate the consumer takes the result this cycle.
REQ-011 result  out  WIDTH  SHALL be the low/primary result.
REQ-012 resultHi  out  WIDTH  SHALL be the high product word; 0 for non-multiply operations.
REQ-013 aluCtr  out  4  SHALL be the registered decoded control code of the completed operation.
REQ-014 zero  out  1  SHALL be 1 when result equals 0 for the completed operation.
REQ-015 illegal  out  1  SHALL be 1 when the completed operation had no valid decode.

Function
REQ-016 Decode SHALL be: aluOp 00 -> add 0010; aluOp 01 -> sub 0110; aluOp 1x by funct[3:0]: 0000 add 0010, 0010 sub 0110, 0100 and 0000, 0101 or 0001, 0111 nor 1100, 1010 slt 0111; funct 011000 with aluOp 1x -> mult 1000; anything else -> illegal, aluCtr 1111.
REQ-017 Add/sub SHALL wrap modulo 2^WIDTH; slt SHALL be signed two's-complement, result 1 or 0; mult SHALL be unsigned 2*WIDTH product, {resultHi,result}.
REQ-018 An operation SHALL be accepted at a rising edge where inValid && inReady; operands, aluOp, funct sampled only then.
REQ-019 FSM states SHALL be IDLE, MUL, HOLD; reset enters IDLE.
REQ-020 IDLE: inReady=1, outValid=0; accept non-mult -> HOLD; accept mult -> MUL.
REQ-021 Non-mult and illegal ops SHALL complete in 1 cycle: results and outValid=1 visible after the accepting edge.
REQ-022 MUL: shift-add, one bit per cycle, 5-bit-or-wider counter; inReady=0; after exactly WIDTH cycles in MUL -> HOLD with results registered.
REQ-023 HOLD: outValid=1, outputs stable; inReady=outReady; outReady without accept -> IDLE; outReady with accept -> HOLD or MUL per new op (back-to-back 1 op/cycle for non-mult).
REQ-024 Illegal ops SHALL return result 0, resultHi 0, zero 1, illegal 1, and follow the normal handshake.
REQ-025 inValid while inReady=0 SHALL be ignored without loss of held results; inputs need not be held stable after acceptance.

Reset
REQ-026 While reset_n=0: state IDLE, inReady 0, outValid 0, result 0, resultHi 0, aluCtr 0000, zero 0, illegal 0, MUL counter 0.
REQ-027 Reset asserted during MUL or HOLD SHALL abort the operation; no partial result is ever presented.
REQ-028 First acceptance possible at the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro ALU_MULT_EN defined: MUL state, multiplier and resultHi implemented per REQ-016/022.
REQ-030 ALU_MULT_EN undefined: no MUL state or multiplier logic; funct 011000 decodes illegal (aluCtr 1111); resultHi tied 0.

Verification (WIDTH=32)
REQ-031 aluOp=10 funct=100000 srcA=7 srcB=5 -> next cycle outValid=1 result=12 aluCtr=0010 zero=0.
REQ-032 aluOp=01 srcA=5 srcB=5 -> result=0 aluCtr=0110 zero=1; then funct=101010 srcA=0xFFFFFFFF srcB=1 -> result=1 aluCtr=0111; funct=100111 srcA=srcB=0 -> result=0xFFFFFFFF aluCtr=1100.
REQ-033 Two back-to-back ops, outReady=0 for 2 cycles -> first result held, inReady=0; second accepted on the outReady=1 cycle, its result next cycle.
REQ-034 With ALU_MULT_EN: funct=011000 srcA=srcB=0x00010000 -> inReady=0 for 32 cycles, then resultHi=1 result=0 aluCtr=1000; without macro -> 1 cycle, illegal=1 aluCtr=1111.
REQ-035 reset_n low 10 cycles into a mult -> outValid=0, all outputs at reset values; after release an add 3+4 returns 7 in 1 cycle.
REQ-036 aluOp=10 funct=001011 -> illegal=1 aluCtr=1111 result=0 zero=1, handshake completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with an optional multi-cycle multiplier.
//
// An operation is accepted on a rising edge where inValid && inReady. Single-cycle ops
// (add, sub, and, or, nor, slt, illegal) present their result on the next cycle. When the
// multiplier is built in, a multiply runs a shift-add loop for WIDTH cycles before the
// result is presented. The result registers hold until the consumer takes them with
// outReady. A new op can be accepted in the same cycle, so single-cycle ops can issue
// back to back at one op per cycle.
//
// Build option: define ALU_MULT_EN to include the MUL state, the multiplier and resultHi.
// Without it, funct 011000 decodes as illegal and resultHi is tied to 0.
//
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   inValid   operation presented          inReady   unit accepts this cycle
//   aluOp     main-decoder ALU class       funct     R-type function field
//   srcA/srcB operands (WIDTH bits)
//   outValid  result outputs hold a completed op
//   outReady  consumer takes the result this cycle
//   result    low/primary result           resultHi  high product word (0 for non-mult)
//   aluCtr    decoded control code of the completed op
//   zero      result == 0                  illegal   completed op had no valid decode
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic [3:0]       aluCtr,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] CtrAnd = 4'b0000;
  localparam logic [3:0] CtrOr  = 4'b0001;
  localparam logic [3:0] CtrAdd = 4'b0010;
  localparam logic [3:0] CtrSub = 4'b0110;
  localparam logic [3:0] CtrSlt = 4'b0111;
  localparam logic [3:0] CtrMul = 4'b1000;
  localparam logic [3:0] CtrNor = 4'b1100;
  localparam logic [3:0] CtrIll = 4'b1111;

`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;
  // Counts the WIDTH multiply iterations; never narrower than 5 bits.
  localparam int unsigned CntW = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       alu_ctr_q, alu_ctr_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
`endif

  logic             accept;
  logic             is_mult_code;
  logic [3:0]       dec_ctr;
  logic             dec_illegal;
  logic             dec_mult;
  logic [WIDTH-1:0] exec_res;

  // Operation decode
  assign is_mult_code = (funct == 6'b011000);

  always_comb begin
    dec_ctr     = CtrIll;
    dec_illegal = 1'b1;
    dec_mult    = 1'b0;
    case (aluOp)
      2'b00: begin
        dec_ctr     = CtrAdd;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_ctr     = CtrSub;
        dec_illegal = 1'b0;
      end
      default: begin
        if (is_mult_code) begin
`ifdef ALU_MULT_EN
          dec_ctr     = CtrMul;
          dec_illegal = 1'b0;
          dec_mult    = 1'b1;
`else
          dec_ctr     = CtrIll;
          dec_illegal = 1'b1;
`endif
        end else begin
          dec_illegal = 1'b0;
          case (funct[3:0])
            4'b0000: dec_ctr = CtrAdd;
            4'b0010: dec_ctr = CtrSub;
            4'b0100: dec_ctr = CtrAnd;
            4'b0101: dec_ctr = CtrOr;
            4'b0111: dec_ctr = CtrNor;
            4'b1010: dec_ctr = CtrSlt;
            default: begin
              dec_ctr     = CtrIll;
              dec_illegal = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  // Single-cycle datapath; illegal codes fall through to 0
  always_comb begin
    exec_res = {WIDTH{1'b0}};
    case (dec_ctr)
      CtrAdd:  exec_res = srcA + srcB;
      CtrSub:  exec_res = srcA - srcB;
      CtrAnd:  exec_res = srcA & srcB;
      CtrOr:   exec_res = srcA | srcB;
      CtrNor:  exec_res = ~(srcA | srcB);
      CtrSlt:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: exec_res = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_MULT_EN
  // One shift-add step: conditionally add the multiplicand into the high half, then shift
  // the {carry, hi, lo} pair right. The multiplier bits drain out of lo as product bits
  // shift in.
  assign mul_sum     = {1'b0, prod_hi_q} + {1'b0, (prod_lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
`endif

  // Handshake outputs. inReady is forced low while reset is held.
  always_comb begin
    inReady = 1'b0;
    case (state_q)
      StIdle:  inReady = reset_n;
      StHold:  inReady = outReady;
      default: inReady = 1'b0;
    endcase
  end

  assign outValid = (state_q == StHold);
  assign accept   = inValid && inReady;

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    alu_ctr_d   = alu_ctr_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifdef ALU_MULT_EN
    result_hi_d = result_hi_q;
    mcand_d     = mcand_q;
    prod_hi_d   = prod_hi_q;
    prod_lo_d   = prod_lo_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      StIdle, StHold: begin
        if (accept) begin
`ifdef ALU_MULT_EN
          if (dec_mult) begin
            // Result registers keep their old values; outValid is low while multiplying.
            mcand_d   = srcA;
            prod_hi_d = {WIDTH{1'b0}};
            prod_lo_d = srcB;
            cnt_d     = {CntW{1'b0}};
            state_d   = StMul;
          end else begin
            result_d    = exec_res;
            result_hi_d = {WIDTH{1'b0}};
            alu_ctr_d   = dec_ctr;
            zero_d      = (exec_res == {WIDTH{1'b0}});
            illegal_d   = dec_illegal;
            state_d     = StHold;
          end
`else
          result_d  = exec_res;
          alu_ctr_d = dec_ctr;
          zero_d    = (exec_res == {WIDTH{1'b0}});
          illegal_d = dec_illegal;
          state_d   = StHold;
`endif
        end else if (state_q == StHold && outReady) begin
          state_d = StIdle;
        end
      end
`ifdef ALU_MULT_EN
      StMul: begin
        prod_hi_d = mul_hi_next;
        prod_lo_d = mul_lo_next;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last iteration: publish the full product together with the state change.
          result_d    = mul_lo_next;
          result_hi_d = mul_hi_next;
          alu_ctr_d   = CtrMul;
          zero_d      = (mul_lo_next == {WIDTH{1'b0}});
          illegal_d   = 1'b0;
          cnt_d       = {CntW{1'b0}};
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      result_q    <= {WIDTH{1'b0}};
      alu_ctr_q   <= 4'b0000;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_MULT_EN
      result_hi_q <= {WIDTH{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      prod_hi_q   <= {WIDTH{1'b0}};
      prod_lo_q   <= {WIDTH{1'b0}};
      cnt_q       <= {CntW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      alu_ctr_q   <= alu_ctr_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_MULT_EN
      result_hi_q <= result_hi_d;
      mcand_q     <= mcand_d;
      prod_hi_q   <= prod_hi_d;
      prod_lo_q   <= prod_lo_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign result  = result_q;
  assign aluCtr  = alu_ctr_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;
`ifdef ALU_MULT_EN
  assign resultHi = result_hi_q;
`else
  assign resultHi = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=32). Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on rising edges.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   alu_ctr;
  logic         zero;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .aluOp    (alu_op),
    .funct    (funct),
    .srcA     (src_a),
    .srcB     (src_b),
    .outValid (out_valid),
    .outReady (out_ready),
    .result   (result),
    .resultHi (result_hi),
    .aluCtr   (alu_ctr),
    .zero     (zero),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"},    64'(result),    64'd0);
    check({tag, "_result_hi"}, 64'(result_hi), 64'd0);
    check({tag, "_alu_ctr"},   64'(alu_ctr),   64'd0);
    check({tag, "_zero"},      64'(zero),      64'd0);
    check({tag, "_illegal"},   64'(illegal),   64'd0);
  endtask

  typedef struct packed {
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   ctr;
    logic         z;
    logic         ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int waited;
    int ready_seen;

    vecs[0] = '{2'b01, 6'b000000, 32'd5,          32'd5,          32'd0,          4'h6, 1'b1, 1'b0};
    vecs[1] = '{2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1,          4'h7, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 6'b100111, 32'd0,          32'd0,          32'hFFFF_FFFF,  4'hC, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 6'b100100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  4'h0, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 6'b100101, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  4'h1, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 6'b111111, 32'hFFFF_FFFF,  32'd2,          32'd1,          4'h2, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 6'b101010, 32'd1,          32'hFFFF_FFFF,  32'd0,          4'h7, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 6'b100010, 32'd3,          32'd5,          32'hFFFF_FFFE,  4'h6, 1'b0, 1'b0};
    vecs[8] = '{2'b10, 6'b001011, 32'd7,          32'd7,          32'd0,          4'hF, 1'b1, 1'b1};
    vecs[9] = '{2'b10, 6'b100000, 32'h8000_0000,  32'h8000_0000,  32'd0,          4'h2, 1'b1, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 2'b00;
    funct     = 6'b0;
    src_a     = '0;
    src_b     = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Release reset with an op already presented: accepted at the very next edge.
    reset_n = 1'b1;
    present(2'b10, 6'b100000, 32'd7, 32'd5);
    #1;
    check("rdy_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'd12);
    check("add_ctr", 64'(alu_ctr), 64'h2);
    check("add_zero", 64'(zero), 64'd0);
    check("add_hi", 64'(result_hi), 64'd0);

    // Back-to-back single-cycle ops, one per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      present(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("v%0d_ctr", i), 64'(alu_ctr), 64'(vecs[i].ctr));
      check($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
      check($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vecs[i].ill));
    end

    // Drain to idle.
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);

    // Backpressure: first result held while the second op waits.
    out_ready = 1'b0;
    present(2'b00, 6'b0, 32'd10, 32'd20);
    @(negedge clk);
    present(2'b01, 6'b0, 32'd100, 32'd1);
    #1;
    check("bp_ready0", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_hold1_valid", 64'(out_valid), 64'd1);
    check("bp_hold1_result", 64'(result), 64'd30);
    check("bp_hold1_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_hold2_result", 64'(result), 64'd30);
    check("bp_hold2_ctr", 64'(alu_ctr), 64'h2);
    out_ready = 1'b1;
    #1;
    check("bp_ready1", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_second_result", 64'(result), 64'd99);
    check("bp_second_ctr", 64'(alu_ctr), 64'h6);
    in_valid = 1'b0;
    @(negedge clk);

`ifdef ALU_MULT_EN
    // Multiply: 0x10000 * 0x10000 = 2^32. An add is kept presented during the multiply and
    // must be ignored.
    out_ready = 1'b0;
    present(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    present(2'b00, 6'b0, 32'd1, 32'd1);
    waited = 0;
    ready_seen = 0;
    while (!out_valid && waited < 100) begin
      if (in_ready) ready_seen++;
      @(negedge clk);
      waited++;
    end
    check("mul1_cycles", 64'(waited), 64'd32);
    check("mul1_ready_low", 64'(ready_seen), 64'd0);
    check("mul1_hi", 64'(result_hi), 64'd1);
    check("mul1_lo", 64'(result), 64'd0);
    check("mul1_ctr", 64'(alu_ctr), 64'h8);
    check("mul1_zero", 64'(zero), 64'd1);
    check("mul1_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    check("mul1_held_hi", 64'(result_hi), 64'd1);

    // Take the result and issue 0xFFFFFFFF * 0xFFFFFFFF back to back.
    out_ready = 1'b1;
    present(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("mul2_cycles", 64'(waited), 64'd32);
    check("mul2_hi", 64'(result_hi), 64'hFFFF_FFFE);
    check("mul2_lo", 64'(result), 64'd1);
    check("mul2_zero", 64'(zero), 64'd0);

    // 0xFFFFFFFF * 3 = 0x2_FFFFFFFD
    out_ready = 1'b1;
    present(2'b11, 6'b011000, 32'hFFFF_FFFF, 32'd3);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("mul3_cycles", 64'(waited), 64'd32);
    check("mul3_hi", 64'(result_hi), 64'd2);
    check("mul3_lo", 64'(result), 64'hFFFF_FFFD);

    // Non-mult after a mult clears resultHi.
    out_ready = 1'b1;
    present(2'b00, 6'b0, 32'd2, 32'd2);
    @(negedge clk);
    check("after_mul_hi", 64'(result_hi), 64'd0);
    check("after_mul_result", 64'(result), 64'd4);
    in_valid = 1'b0;
    @(negedge clk);
`else
    // Without the multiplier, the mult code is a single-cycle illegal op.
    out_ready = 1'b0;
    present(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    in_valid = 1'b0;
    check("mulx_valid", 64'(out_valid), 64'd1);
    check("mulx_illegal", 64'(illegal), 64'd1);
    check("mulx_ctr", 64'(alu_ctr), 64'hF);
    check("mulx_result", 64'(result), 64'd0);
    check("mulx_hi", 64'(result_hi), 64'd0);
    check("mulx_zero", 64'(zero), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("mulx_drained", 64'(out_valid), 64'd0);
`endif

    // Reset in the middle of a multiply (or while holding, without the multiplier).
    out_ready = 1'b0;
    present(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");

    reset_n   = 1'b1;
    out_ready = 1'b1;
    present(2'b00, 6'b0, 32'd3, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_result", 64'(result), 64'd7);
    check("post_rst_ctr", 64'(alu_ctr), 64'h2);
    check("post_rst_hi", 64'(result_hi), 64'd0);
    @(negedge clk);
    check("post_rst_idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
